// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU control decode, registered ALU result and iterative multiply/divide unit.
// Define MDU_DIV_EN to build the restoring divider; without it DIV-class ops return 0 in one cycle.
module alu_ctrl_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      ALU_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t            state, state_nx;
    logic [XLEN-1:0]   hi, lo, mc, step_hi, step_lo, fin_res, fast_res, div_fast, alu_res;
    logic [XLEN-1:0]   mag_a, mag_b, mul_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [CW-1:0]     cnt;
    logic [1:0]        op;
    logic              neg, is_m, sa, sb, na, nb, go_mul, go_div, last, accept;

    always_comb begin
        ALUControl = 4'b0010;
        if (ALU_op == 2'b01)
            ALUControl = 4'b0110;
        else if (ALU_op[1])
            case (funct3)
                3'b000:  ALUControl = (ALU_op == 2'b10 && funct7[5]) ? 4'b0110 : 4'b0010;
                3'b111:  ALUControl = 4'b0000;
                3'b110:  ALUControl = 4'b0001;
                3'b100:  ALUControl = 4'b0011;
                3'b001:  ALUControl = 4'b0100;
                3'b101:  ALUControl = funct7[5] ? 4'b0111 : 4'b0101;
                3'b010:  ALUControl = 4'b1000;
                default: ALUControl = 4'b1001;
            endcase
    end

    always_comb begin
        case (ALUControl)
            4'b0110: alu_res = op_a - op_b;
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0011: alu_res = op_a ^ op_b;
            4'b0100: alu_res = op_a << op_b[CW-1:0];
            4'b0101: alu_res = op_a >> op_b[CW-1:0];
            4'b0111: alu_res = XLEN'($signed(op_a) >>> op_b[CW-1:0]);
            4'b1000: alu_res = XLEN'($signed(op_a) < $signed(op_b));
            4'b1001: alu_res = XLEN'(op_a < op_b);
            default: alu_res = op_a + op_b;
        endcase
    end

    // Operand signedness: MULH both, MULHSU only a, DIV/REM both, unsigned variants none
    always_comb begin
        is_m   = ALU_op == 2'b10 && funct7 == 7'b0000001;
        sa     = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        sb     = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
        na     = sa && op_a[XLEN-1];
        nb     = sb && op_b[XLEN-1];
        mag_a  = na ? -op_a : op_a;
        mag_b  = nb ? -op_b : op_b;
        go_mul = accept && is_m && !funct3[2];
        last   = cnt == CW'(XLEN - 1);
    end

    // One shift-add step: hi accumulates, lo holds the remaining multiplier bits
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
        prod    = {mul_sum, lo[XLEN-1:1]};
        prod_s  = neg ? -prod : prod;
        mul_res = op == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

`ifdef MDU_DIV_EN
    logic [XLEN:0]   rem_t;
    logic [XLEN-1:0] div_hi, div_lo, quo, rem;
    logic            ge, dz, ovf, neg_r;

    // One restoring step: hi is the partial remainder, lo shifts dividend out and quotient in
    always_comb begin
        rem_t    = {hi, lo[XLEN-1]};
        ge       = rem_t >= {1'b0, mc};
        div_hi   = ge ? XLEN'(rem_t - {1'b0, mc}) : rem_t[XLEN-1:0];
        div_lo   = {lo[XLEN-2:0], ge};
        quo      = neg ? -div_lo : div_lo;
        rem      = neg_r ? -div_hi : div_hi;
        dz       = op_b == '0;
        ovf      = !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
        go_div   = accept && is_m && funct3[2] && !dz && !ovf;
        div_fast = dz ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
        step_hi  = state == DIV ? div_hi : mul_sum[XLEN:1];
        step_lo  = state == DIV ? div_lo : {mul_sum[0], lo[XLEN-1:1]};
        fin_res  = state == DIV ? (op[1] ? rem : quo) : mul_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            neg_r <= 1'b0;
        else if (go_div)
            neg_r <= na;
    end
`else
    always_comb begin
        go_div   = 1'b0;
        div_fast = '0;
        step_hi  = mul_sum[XLEN:1];
        step_lo  = {mul_sum[0], lo[XLEN-1:1]};
        fin_res  = mul_res;
    end
`endif

    always_comb fast_res = is_m ? div_fast : alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb state_nx = state == IDLE ? (go_mul ? MUL : go_div ? DIV : IDLE) : last ? IDLE : state;

    always_comb begin
        ready_o = state == IDLE;
        accept  = valid_i && ready_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hi, lo, mc, result_o} <= '0;
            cnt     <= '0;
            op      <= '0;
            neg     <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (go_mul || go_div) begin
                hi  <= '0;
                cnt <= '0;
                op  <= funct3[1:0];
                lo  <= go_mul ? mag_b : mag_a;
                mc  <= go_mul ? mag_a : mag_b;
                neg <= na ^ nb;
            end else if (accept) begin
                result_o <= fast_res;
                valid_o  <= 1'b1;
            end else if (!ready_o) begin
                hi  <= step_hi;
                lo  <= step_lo;
                cnt <= cnt + CW'(1);
                if (last) begin
                    result_o <= fin_res;
                    valid_o  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: randomized and directed checks of alu_ctrl_mdu (XLEN=32) against a behavioural model.
module tb_alu_ctrl_mdu;
    logic        clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0;
    logic [1:0]  ALU_op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] op_a = '0, op_b = '0, result_o;
    logic [3:0]  ALUControl;
    logic        ready_o, valid_o;
    int          n_chk = 0, n_fail = 0;

    alu_ctrl_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .ALU_op(ALU_op),
        .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b), .ALUControl(ALUControl),
        .result_o(result_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] ref_ctl(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7);
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0110;
        case (f3)
            3'b000:  return (aop == 2'b10 && f7[5]) ? 4'b0110 : 4'b0010;
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            3'b100:  return 4'b0011;
            3'b001:  return 4'b0100;
            3'b101:  return f7[5] ? 4'b0111 : 4'b0101;
            3'b010:  return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p, q, r;
        int sh;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        sh = int'(b[4:0]);
        if (aop == 2'b10 && f7 == 7'b0000001) begin
            case (f3)
                3'b000: begin p = ua * ub; return p[31:0]; end
                3'b001: begin p = sa * sb; return p[63:32]; end
                3'b010: begin p = sa * ub; return p[63:32]; end
                3'b011: begin p = ua * ub; return p[63:32]; end
                default: begin
`ifdef MDU_DIV_EN
                    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
                    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : a;
                    q = f3[0] ? ua / ub : sa / sb;
                    r = f3[0] ? ua % ub : sa % sb;
                    return f3[1] ? r[31:0] : q[31:0];
`else
                    return 32'h0;
`endif
                end
            endcase
        end
        case (ref_ctl(aop, f3, f7))
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0011: return a ^ b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b0111: return 32'($signed(a) >>> sh);
            4'b1000: return {31'b0, $signed(a) < $signed(b)};
            4'b1001: return {31'b0, a < b};
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!(aop == 2'b10 && f7 == 7'b0000001)) return 1;
        if (!f3[2]) return 33;
`ifdef MDU_DIV_EN
        if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    // Drives one request, scrambles operands after acceptance, and measures the response
    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, output logic [3:0] ctl,
                         output logic [31:0] res, output int lat, output int rdy_bad, output logic dbl);
        @(negedge clk);
        ALU_op = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b; valid_i = 1'b1;
        #1 ctl = ALUControl;
        @(negedge clk);
        valid_i = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = 1; rdy_bad = 0;
        while (!valid_o && lat < 100) begin
            if (ready_o) rdy_bad++;
            @(negedge clk);
            lat++;
        end
        res = result_o;
        if (!ready_o) rdy_bad++;
        @(negedge clk);
        dbl = valid_o || (result_o !== res);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", result_o); end
        n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
        n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        logic [3:0] c; logic [31:0] r; int l, rb; logic d;
        issue(2'b10, 3'b000, 7'h00, 32'd5, 32'd3, c, r, l, rb, d);
        n_chk++; if (c !== 4'b0010) begin n_fail++; $display("FAIL add_ctl: got %b exp 0010", c); end
        n_chk++; if (r !== 32'd8) begin n_fail++; $display("FAIL add_res: got %h exp 8", r); end
        n_chk++; if (l !== 1) begin n_fail++; $display("FAIL add_lat: got %0d exp 1", l); end
        issue(2'b10, 3'b000, 7'h20, 32'd3, 32'd5, c, r, l, rb, d);
        n_chk++; if (c !== 4'b0110) begin n_fail++; $display("FAIL sub_ctl: got %b exp 0110", c); end
        n_chk++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_res: got %h exp fffffffe", r); end
        n_chk++; if (l !== 1 || d !== 1'b0) begin n_fail++; $display("FAIL sub_lat: got lat %0d dbl %b exp 1 0", l, d); end
    endtask

    task automatic test_mul();
        logic [3:0] c; logic [31:0] r; int l, rb; logic d;
        logic [2:0]  f3s [3] = '{3'b000, 3'b011, 3'b001};
        logic [31:0] exps[3] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(2'b10, f3s[i], 7'h01, 32'hFFFF_FFFF, 32'd2, c, r, l, rb, d);
            n_chk++; if (r !== exps[i]) begin n_fail++; $display("FAIL mul_res f3=%0d: got %h exp %h", f3s[i], r, exps[i]); end
            n_chk++; if (l !== 33) begin n_fail++; $display("FAIL mul_lat f3=%0d: got %0d exp 33", f3s[i], l); end
            n_chk++; if (rb !== 0) begin n_fail++; $display("FAIL mul_ready f3=%0d: %0d bad cycles exp 0", f3s[i], rb); end
            n_chk++; if (d !== 1'b0) begin n_fail++; $display("FAIL mul_hold f3=%0d: got %b exp 0", f3s[i], d); end
        end
    endtask

    task automatic test_div();
        logic [3:0] c; logic [31:0] r, e; int l, rb; logic d;
        logic [2:0]  f3s[6] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            issue(2'b10, f3s[i], 7'h01, as[i], bs[i], c, r, l, rb, d);
            e = ref_res(2'b10, f3s[i], 7'h01, as[i], bs[i]);
            n_chk++; if (r !== e) begin n_fail++; $display("FAIL div_res %0d: got %h exp %h", i, r, e); end
            n_chk++; if (l !== ref_lat(2'b10, f3s[i], 7'h01, as[i], bs[i])) begin n_fail++; $display("FAIL div_lat %0d: got %0d", i, l); end
            n_chk++; if (rb !== 0 || d !== 1'b0) begin n_fail++; $display("FAIL div_hs %0d: ready bad %0d dbl %b exp 0 0", i, rb, d); end
        end
    endtask

    task automatic test_random();
        logic [3:0] c; logic [31:0] r, a, b, e; int l, rb, el; logic d; logic [1:0] aop; logic [2:0] f3; logic [6:0] f7;
        for (int i = 0; i < 60; i++) begin
            aop = 2'($urandom); f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1 && aop != 2'b10) aop = 2'b10;
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(aop, f3, f7, a, b, c, r, l, rb, d);
            e = ref_res(aop, f3, f7, a, b); el = ref_lat(aop, f3, f7, a, b);
            n_chk++; if (c !== ref_ctl(aop, f3, f7)) begin n_fail++; $display("FAIL rnd_ctl %0d: got %b exp %b", i, c, ref_ctl(aop, f3, f7)); end
            n_chk++; if (r !== e) begin n_fail++; $display("FAIL rnd_res %0d op=%b f3=%b f7=%h a=%h b=%h: got %h exp %h", i, aop, f3, f7, a, b, r, e); end
            n_chk++; if (l !== el) begin n_fail++; $display("FAIL rnd_lat %0d: got %0d exp %0d", i, l, el); end
            n_chk++; if (rb !== 0 || d !== 1'b0) begin n_fail++; $display("FAIL rnd_hs %0d: ready bad %0d dbl %b exp 0 0", i, rb, d); end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        ALU_op = 2'b10; funct3 = 3'b000; funct7 = 7'h01; op_a = 32'd12345; op_b = 32'd678; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b exp 0", valid_o); end
        n_chk++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h exp 0", result_o); end
        n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b exp 1", ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        ALU_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00; op_a = 32'd1; op_b = 32'd2; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        n_chk++; if (valid_o !== 1'b1 || result_o !== 32'd3) begin n_fail++; $display("FAIL rstmid_add: got v=%b r=%h exp 1 3", valid_o, result_o); end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d pulses exp 0", pulses); end
    endtask

    task automatic test_back_to_back(input logic [2:0] f3);
        int pulses; logic [31:0] got, e;
        @(negedge clk);
        ALU_op = 2'b10; funct3 = f3; funct7 = 7'h01; op_a = 32'd1000; op_b = 32'd7; valid_i = 1'b1;
        e = ref_res(2'b10, f3, 7'h01, 32'd1000, 32'd7);
        @(negedge clk);
        valid_i = 1'b0; pulses = 0; got = 'x;
        for (int i = 1; i <= 45; i++) begin
            if (i == 3) begin valid_i = 1'b1; ALU_op = 2'b00; op_a = 32'd5; op_b = 32'd6; end
            if (i == 4) valid_i = 1'b0;
            if (valid_o) begin pulses++; got = result_o; end
            @(negedge clk);
        end
        n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_pulses f3=%0d: got %0d exp 1", f3, pulses); end
        n_chk++; if (got !== e) begin n_fail++; $display("FAIL b2b_res f3=%0d: got %h exp %h", f3, got, e); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_random();
        test_reset_mid();
        test_back_to_back(3'b000);
`ifdef MDU_DIV_EN
        test_back_to_back(3'b100);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
